muldiv_unit: RTL and testbench

- Execute-stage multiply/divide unit. It produces the E_MulDiv_Out value that the E/M pipeline register captures, and owns the architectural HI/LO registers.
- Multi-cycle MULT/MULTU/DIV/DIVU operations run behind a Busy flag. The hazard unit stalls D whenever Start or Busy is high and a muldiv-class instruction is in D.
- MFHI/MFLO read HI/LO combinationally. MTHI/MTLO write them in one cycle.

---
 rtl/muldiv_unit.sv | 135 +++++++++++++
 tb/tb_muldiv_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - execute-stage multiply/divide unit owning HI/LO
// Result is computed at launch into a shadow pair and committed after a fixed Busy window.
module muldiv_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  E_MD_Op,
  input  logic        E_MD_Start,
  input  logic [31:0] E_RS,
  input  logic [31:0] E_RT,
  output logic        E_MD_Busy,
  output logic [31:0] E_MulDiv_Out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          launch, commit;
  logic [31:0]   sh_hi, sh_lo;
  logic          sh_wr;

  logic        is_mul, is_sdiv;
  logic [63:0] prod_s, prod_u;
  logic        sgn_a, sgn_b;
  logic [31:0] mag_a, mag_b, dvd, dvs, dvs_safe, q_u, r_u, quo, rem;
  logic [31:0] res_hi, res_lo;

  assign is_mul  = (E_MD_Op == OP_MULT) || (E_MD_Op == OP_MULTU);
  assign is_sdiv = (E_MD_Op == OP_DIV);

  assign prod_u = {32'b0, E_RS} * {32'b0, E_RT};
  assign prod_s = $signed({{32{E_RS[31]}}, E_RS}) * $signed({{32{E_RT[31]}}, E_RT});

  // Signed divide runs on magnitudes; this also yields 0x80000000 / -1 = 0x80000000 rem 0.
  assign sgn_a    = E_RS[31];
  assign sgn_b    = E_RT[31];
  assign mag_a    = sgn_a ? -E_RS : E_RS;
  assign mag_b    = sgn_b ? -E_RT : E_RT;
  assign dvd      = is_sdiv ? mag_a : E_RS;
  assign dvs      = is_sdiv ? mag_b : E_RT;
  assign dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
  assign q_u      = dvd / dvs_safe;
  assign r_u      = dvd % dvs_safe;
  assign quo      = (is_sdiv && (sgn_a ^ sgn_b)) ? -q_u : q_u;
  assign rem      = (is_sdiv && sgn_a) ? -r_u : r_u;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (E_MD_Op)
      OP_MULT:         begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      OP_MULTU:        begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      OP_DIV, OP_DIVU: begin res_hi = rem;           res_lo = quo;          end
      default:         ;
    endcase
  end

  assign launch = (state == IDLE) && E_MD_Start &&
                  (E_MD_Op >= OP_MULT) && (E_MD_Op <= OP_DIVU);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (launch) begin
          state_d = RUN;
          cnt_d   = is_mul ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
        end
      end
      RUN: begin
        cnt_d = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      sh_hi <= 32'd0;
      sh_lo <= 32'd0;
      sh_wr <= 1'b0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (launch) begin
        sh_hi <= res_hi;
        sh_lo <= res_lo;
        sh_wr <= is_mul || (E_RT != 32'd0);
      end
      if (commit && sh_wr) begin
        HI <= sh_hi;
        LO <= sh_lo;
      end else if ((state == IDLE) && !E_MD_Start) begin
        if (E_MD_Op == OP_MTHI) HI <= E_RS;
        if (E_MD_Op == OP_MTLO) LO <= E_RS;
      end
    end
  end

  assign E_MD_Busy = (state == RUN);

  always_comb begin
    E_MulDiv_Out = 32'd0;
    if (E_MD_Op == OP_MFHI) E_MulDiv_Out = HI;
    if (E_MD_Op == OP_MFLO) E_MulDiv_Out = LO;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  E_MD_Op = 4'd0;
  logic        E_MD_Start = 1'b0;
  logic [31:0] E_RS = 32'd0;
  logic [31:0] E_RT = 32'd0;
  logic        E_MD_Busy;
  logic [31:0] E_MulDiv_Out, HI, LO;

  int pass_cnt = 0;
  int total_cnt = 0;

  muldiv_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .E_MD_Op(E_MD_Op), .E_MD_Start(E_MD_Start),
    .E_RS(E_RS), .E_RT(E_RT), .E_MD_Busy(E_MD_Busy),
    .E_MulDiv_Out(E_MulDiv_Out), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Launch at the next edge, then count Busy cycles (bounded) and check HI/LO.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int ncyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    @(negedge clk);
    E_MD_Op = op; E_MD_Start = 1'b1; E_RS = a; E_RT = b;
    @(negedge clk);
    E_MD_Op = 4'd0; E_MD_Start = 1'b0;
    cyc = 0;
    while (E_MD_Busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_cycles"}, cyc, ncyc);
    check({tag, "_hi"}, HI, exp_hi);
    check({tag, "_lo"}, LO, exp_lo);
  endtask

  initial begin
    int cyc;
    logic seen6;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    E_MD_Op = 4'd5; #1;
    check("reset_mfhi", E_MulDiv_Out, 32'h0);
    E_MD_Op = 4'd6; #1;
    check("reset_mflo", E_MulDiv_Out, 32'h0);
    check("reset_busy", {31'b0, E_MD_Busy}, 32'h0);
    E_MD_Op = 4'd0;

    run_op("mult", 4'd1, 32'hFFFFFFFD, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    E_MD_Op = 4'd6; #1;
    check("mflo_after_mult", E_MulDiv_Out, 32'hFFFFFFF1);
    E_MD_Op = 4'd5; #1;
    check("mfhi_after_mult", E_MulDiv_Out, 32'hFFFFFFFF);
    E_MD_Op = 4'd0;

    run_op("multu", 4'd2, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
    run_op("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_negdvs", 4'd3, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
    run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);
    run_op("divu", 4'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);

    @(negedge clk);
    E_MD_Op = 4'd7; E_RS = 32'h1234;
    @(negedge clk);
    E_MD_Op = 4'd0;
    check("mthi", HI, 32'h1234);
    run_op("divu_zero", 4'd4, 32'd7, 32'd0, 10, 32'h1234, 32'd3);

    // MTLO together with Start is ignored; alone it writes.
    @(negedge clk);
    E_MD_Op = 4'd8; E_MD_Start = 1'b1; E_RS = 32'hDEAD;
    @(negedge clk);
    E_MD_Start = 1'b0; E_MD_Op = 4'd0;
    check("mtlo_with_start", LO, 32'd3);
    check("op_oob_start_busy", {31'b0, E_MD_Busy}, 32'h0);
    E_MD_Op = 4'd8; E_RS = 32'hABCD;
    @(negedge clk);
    E_MD_Op = 4'd0;
    check("mtlo", LO, 32'hABCD);

    // Start/MTLO during Busy must not restart or write.
    E_MD_Op = 4'd1; E_MD_Start = 1'b1; E_RS = 32'd2; E_RT = 32'd3;
    @(negedge clk);
    E_MD_Op = 4'd0; E_MD_Start = 1'b0;
    cyc = 0;
    while (E_MD_Busy && cyc < 100) begin
      cyc++;
      if (cyc == 2) begin E_MD_Op = 4'd3; E_MD_Start = 1'b1; E_RS = 32'd100; E_RT = 32'd7; end
      else if (cyc == 3) begin E_MD_Op = 4'd8; E_MD_Start = 1'b0; E_RS = 32'h5555; end
      else begin E_MD_Op = 4'd0; E_MD_Start = 1'b0; end
      @(negedge clk);
    end
    E_MD_Op = 4'd0; E_MD_Start = 1'b0;
    check("robust_cycles", cyc, 5);
    check("robust_hi", HI, 32'h0);
    check("robust_lo", LO, 32'd6);

    // Async reset in the 3rd Busy cycle aborts the operation.
    @(negedge clk);
    E_MD_Op = 4'd8; E_RS = 32'h0;
    @(negedge clk);
    E_MD_Op = 4'd1; E_MD_Start = 1'b1; E_RS = 32'd2; E_RT = 32'd3;
    @(negedge clk);
    E_MD_Op = 4'd0; E_MD_Start = 1'b0;
    check("abort_busy_pre", {31'b0, E_MD_Busy}, 32'h1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", {31'b0, E_MD_Busy}, 32'h0);
    check("abort_hi", HI, 32'h0);
    check("abort_lo", LO, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen6 = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (LO == 32'd6 || E_MD_Busy) seen6 = 1'b1;
    end
    check("abort_no_commit", {31'b0, seen6}, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
